// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
// Bubbles clear every control bit and zero the data fields, but keep ALU code ADD so the ALU always sees a defined operation.
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_pc,
    input  logic [WIDTH-1:0] d_rs1_data,
    input  logic [WIDTH-1:0] d_rs2_data,
    input  logic [WIDTH-1:0] d_imm,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic [4:0]       d_rd,
    input  logic [3:0]       d_alu_ctrl,
    input  logic             d_src_a_pc,
    input  logic             d_src_b_imm,
    input  logic             d_reg_write,
    input  logic             d_mem_read,
    input  logic             d_mem_write,
    input  logic             d_branch,
    input  logic             d_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       xm_rd,
    input  logic             xm_reg_write,
    input  logic [WIDTH-1:0] xm_result,
    input  logic [4:0]       mw_rd,
    input  logic             mw_reg_write,
    input  logic [WIDTH-1:0] mw_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] store_data,
    output logic [WIDTH-1:0] e_pc,
    output logic [WIDTH-1:0] e_imm,
    output logic [4:0]       e_rd,
    output logic             e_reg_write,
    output logic             e_mem_read,
    output logic             e_mem_write,
    output logic             e_branch,
    output logic             e_valid,
    output logic             load_use_stall
);

    localparam logic [3:0] AluAdd = 4'b0010;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] rs1Data;
        logic [WIDTH-1:0] rs2Data;
        logic [WIDTH-1:0] imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [3:0]       aluCtrl;
        logic             srcAPc;
        logic             srcBImm;
        logic             regWrite;
        logic             memRead;
        logic             memWrite;
        logic             branch;
        logic             valid;
    } stage_t;

    stage_t stage_q, stage_d, bubble, captured;
    logic [WIDTH-1:0] fwdRs1, fwdRs2;

    always_comb begin
        bubble         = '0;
        bubble.aluCtrl = AluAdd;
    end

    // Decode slot as it would be captured; an invalid slot carries no side effects.
    always_comb begin
        captured.pc       = d_pc;
        captured.rs1Data  = d_rs1_data;
        captured.rs2Data  = d_rs2_data;
        captured.imm      = d_imm;
        captured.rs1      = d_rs1;
        captured.rs2      = d_rs2;
        captured.rd       = d_rd;
        captured.aluCtrl  = d_alu_ctrl;
        captured.srcAPc   = d_src_a_pc;
        captured.srcBImm  = d_src_b_imm;
        captured.regWrite = d_reg_write & d_valid;
        captured.memRead  = d_mem_read & d_valid;
        captured.memWrite = d_mem_write & d_valid;
        captured.branch   = d_branch & d_valid;
        captured.valid    = d_valid;
    end

    assign load_use_stall = stage_q.valid & stage_q.memRead & (stage_q.rd != 5'd0) & d_valid
                          & ((stage_q.rd == d_rs1) | (stage_q.rd == d_rs2));

    always_comb begin
        stage_d = stage_q;
        if (flush || load_use_stall) begin
            stage_d = bubble;
        end else if (!stall) begin
            stage_d = captured;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= bubble;
        end else begin
            stage_q <= stage_d;
        end
    end

    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    always_comb begin
        fwdRs1 = stage_q.rs1Data;
        if (xm_reg_write && (xm_rd != 5'd0) && (xm_rd == stage_q.rs1)) begin
            fwdRs1 = xm_result;
        end else if (mw_reg_write && (mw_rd != 5'd0) && (mw_rd == stage_q.rs1)) begin
            fwdRs1 = mw_result;
        end
    end

    always_comb begin
        fwdRs2 = stage_q.rs2Data;
        if (xm_reg_write && (xm_rd != 5'd0) && (xm_rd == stage_q.rs2)) begin
            fwdRs2 = xm_result;
        end else if (mw_reg_write && (mw_rd != 5'd0) && (mw_rd == stage_q.rs2)) begin
            fwdRs2 = mw_result;
        end
    end

    assign alu_a       = stage_q.srcAPc  ? stage_q.pc  : fwdRs1;
    assign alu_b       = stage_q.srcBImm ? stage_q.imm : fwdRs2;
    assign store_data  = fwdRs2;
    assign alu_ctrl    = stage_q.aluCtrl;
    assign e_pc        = stage_q.pc;
    assign e_imm       = stage_q.imm;
    assign e_rd        = stage_q.rd;
    assign e_reg_write = stage_q.regWrite;
    assign e_mem_read  = stage_q.memRead;
    assign e_mem_write = stage_q.memWrite;
    assign e_branch    = stage_q.branch;
    assign e_valid     = stage_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: capture, forwarding, x0, load-use, flush/stall, reset.
module tb_id_ex_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] d_pc, d_rs1_data, d_rs2_data, d_imm;
    logic [4:0]       d_rs1, d_rs2, d_rd;
    logic [3:0]       d_alu_ctrl;
    logic             d_src_a_pc, d_src_b_imm, d_reg_write, d_mem_read, d_mem_write, d_branch, d_valid;
    logic             stall, flush;
    logic [4:0]       xm_rd, mw_rd;
    logic             xm_reg_write, mw_reg_write;
    logic [WIDTH-1:0] xm_result, mw_result;
    logic [WIDTH-1:0] alu_a, alu_b, store_data, e_pc, e_imm;
    logic [3:0]       alu_ctrl;
    logic [4:0]       e_rd;
    logic             e_reg_write, e_mem_read, e_mem_write, e_branch, e_valid, load_use_stall;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .d_pc(d_pc), .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data), .d_imm(d_imm),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_alu_ctrl(d_alu_ctrl),
        .d_src_a_pc(d_src_a_pc), .d_src_b_imm(d_src_b_imm), .d_reg_write(d_reg_write),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_branch(d_branch), .d_valid(d_valid),
        .stall(stall), .flush(flush),
        .xm_rd(xm_rd), .xm_reg_write(xm_reg_write), .xm_result(xm_result),
        .mw_rd(mw_rd), .mw_reg_write(mw_reg_write), .mw_result(mw_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .store_data(store_data),
        .e_pc(e_pc), .e_imm(e_imm), .e_rd(e_rd), .e_reg_write(e_reg_write),
        .e_mem_read(e_mem_read), .e_mem_write(e_mem_write), .e_branch(e_branch),
        .e_valid(e_valid), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        d_pc = '0; d_rs1_data = '0; d_rs2_data = '0; d_imm = '0;
        d_rs1 = '0; d_rs2 = '0; d_rd = '0; d_alu_ctrl = 4'b0010;
        d_src_a_pc = 0; d_src_b_imm = 0; d_reg_write = 0; d_mem_read = 0;
        d_mem_write = 0; d_branch = 0; d_valid = 0;
        xm_rd = '0; xm_reg_write = 0; xm_result = '0;
        mw_rd = '0; mw_reg_write = 0; mw_result = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1; flush = 1'b1; stall = 1'b1;
        step();
        clear_inputs();
        checks++; if (e_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_e_valid: got %b expected 0", e_valid); end
        checks++; if (alu_ctrl !== 4'b0010) begin errors++; $display("[TB] FAIL reset_alu_ctrl: got %b expected 0010", alu_ctrl); end
        checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin errors++; $display("[TB] FAIL reset_operands: got %h/%h expected 0/0", alu_a, alu_b); end
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_lus: got %b expected 0", load_use_stall); end
    endtask

    task automatic test_capture();
        clear_inputs();
        d_rs1_data = 32'd5; d_rs2_data = 32'd7; d_rs1 = 5'd1; d_rs2 = 5'd2; d_rd = 5'd5;
        d_pc = 32'h100; d_imm = 32'h40; d_reg_write = 1; d_branch = 1; d_valid = 1;
        step();
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin errors++; $display("[TB] FAIL capture_operands: got %h/%h expected 5/7", alu_a, alu_b); end
        checks++; if (alu_ctrl !== 4'b0010 || e_valid !== 1'b1) begin errors++; $display("[TB] FAIL capture_ctrl_valid: got %b/%b expected 0010/1", alu_ctrl, e_valid); end
        checks++; if (e_rd !== 5'd5 || e_reg_write !== 1'b1 || e_branch !== 1'b1 || e_pc !== 32'h100) begin errors++; $display("[TB] FAIL capture_fields: got rd=%0d rw=%b br=%b pc=%h expected 5/1/1/100", e_rd, e_reg_write, e_branch, e_pc); end
        // Operand muxes select PC and immediate; store data stays on rs2.
        d_src_a_pc = 1; d_src_b_imm = 1; d_alu_ctrl = 4'b0110; d_mem_write = 1;
        step();
        checks++; if (alu_a !== 32'h100 || alu_b !== 32'h40) begin errors++; $display("[TB] FAIL capture_pc_imm: got %h/%h expected 100/40", alu_a, alu_b); end
        checks++; if (store_data !== 32'd7 || e_mem_write !== 1'b1 || alu_ctrl !== 4'b0110) begin errors++; $display("[TB] FAIL capture_store: got sd=%h mw=%b ctrl=%b expected 7/1/0110", store_data, e_mem_write, alu_ctrl); end
        // An invalid slot is captured with every control bit cleared.
        d_valid = 0; d_mem_read = 1;
        step();
        checks++; if (e_valid !== 0 || e_reg_write !== 0 || e_mem_write !== 0 || e_mem_read !== 0 || e_branch !== 0) begin errors++; $display("[TB] FAIL capture_invalid_ctrl: got v=%b rw=%b mw=%b mr=%b br=%b expected all 0", e_valid, e_reg_write, e_mem_write, e_mem_read, e_branch); end
        checks++; if (e_pc !== 32'h100 || e_imm !== 32'h40) begin errors++; $display("[TB] FAIL capture_invalid_data: got %h/%h expected 100/40", e_pc, e_imm); end
    endtask

    task automatic test_forward();
        clear_inputs();
        d_rs1 = 5'd3; d_rs1_data = 32'h33; d_rs2 = 5'd3; d_rs2_data = 32'h44; d_valid = 1;
        step();
        d_valid = 0;
        xm_rd = 5'd3; xm_reg_write = 1; xm_result = 32'h11;
        mw_rd = 5'd3; mw_reg_write = 1; mw_result = 32'h22;
        #1;
        checks++; if (alu_a !== 32'h11 || store_data !== 32'h11) begin errors++; $display("[TB] FAIL fwd_xm_priority: got %h/%h expected 11/11", alu_a, store_data); end
        xm_reg_write = 0;
        #1;
        checks++; if (alu_a !== 32'h22 || alu_b !== 32'h22) begin errors++; $display("[TB] FAIL fwd_mw: got %h/%h expected 22/22", alu_a, alu_b); end
        xm_reg_write = 1; xm_rd = 5'd7;
        #1;
        checks++; if (alu_a !== 32'h22) begin errors++; $display("[TB] FAIL fwd_xm_rd_mismatch: got %h expected 22", alu_a); end
        xm_reg_write = 0; mw_reg_write = 0;
        #1;
        checks++; if (alu_a !== 32'h33 || alu_b !== 32'h44) begin errors++; $display("[TB] FAIL fwd_none: got %h/%h expected 33/44", alu_a, alu_b); end
    endtask

    task automatic test_x0();
        clear_inputs();
        d_rs1 = 5'd0; d_rs2 = 5'd0; d_valid = 1;
        step();
        xm_rd = 5'd0; xm_reg_write = 1; xm_result = 32'hFF;
        mw_rd = 5'd0; mw_reg_write = 1; mw_result = 32'hEE;
        #1;
        checks++; if (alu_b !== 32'h0 || store_data !== 32'h0) begin errors++; $display("[TB] FAIL x0_rs2: got %h/%h expected 0/0", alu_b, store_data); end
        checks++; if (alu_a !== 32'h0) begin errors++; $display("[TB] FAIL x0_rs1: got %h expected 0", alu_a); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        d_rd = 5'd4; d_mem_read = 1; d_reg_write = 1; d_valid = 1; d_alu_ctrl = 4'b0000;
        step();
        d_mem_read = 0; d_rd = 5'd9; d_rs1 = 5'd4; d_rs2 = 5'd1; d_valid = 1;
        #1;
        checks++; if (load_use_stall !== 1'b1) begin errors++; $display("[TB] FAIL lus_rs1: got %b expected 1", load_use_stall); end
        d_valid = 0;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("[TB] FAIL lus_invalid_decode: got %b expected 0", load_use_stall); end
        d_valid = 1; d_rs1 = 5'd1; d_rs2 = 5'd4;
        #1;
        checks++; if (load_use_stall !== 1'b1) begin errors++; $display("[TB] FAIL lus_rs2: got %b expected 1", load_use_stall); end
        // Hazard wins over a concurrent stall and inserts a bubble.
        stall = 1;
        step();
        stall = 0;
        checks++; if (e_valid !== 0 || e_mem_read !== 0 || alu_ctrl !== 4'b0010) begin errors++; $display("[TB] FAIL lus_bubble: got v=%b mr=%b ctrl=%b expected 0/0/0010", e_valid, e_mem_read, alu_ctrl); end
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("[TB] FAIL lus_clears: got %b expected 0", load_use_stall); end
        // A load into x0 never creates a hazard.
        d_rd = 5'd0; d_mem_read = 1; d_rs1 = 5'd0; d_rs2 = 5'd0;
        step();
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("[TB] FAIL lus_x0: got %b expected 0", load_use_stall); end
    endtask

    task automatic test_flush_stall();
        clear_inputs();
        d_rs1 = 5'd1; d_rs1_data = 32'hA; d_rs2 = 5'd2; d_rs2_data = 32'hB;
        d_pc = 32'h200; d_rd = 5'd6; d_alu_ctrl = 4'b0110; d_reg_write = 1; d_valid = 1;
        step();
        d_rs1_data = 32'hDEAD; d_rs2_data = 32'hBEEF; d_pc = 32'h999; d_alu_ctrl = 4'b1111; d_rd = 5'd12;
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (alu_a !== 32'hA || alu_b !== 32'hB || alu_ctrl !== 4'b0110 || e_valid !== 1 || e_pc !== 32'h200 || e_rd !== 5'd6 || e_reg_write !== 1) begin
                errors++; $display("[TB] FAIL stall_hold%0d: got a=%h b=%h ctrl=%b v=%b pc=%h rd=%0d expected A/B/0110/1/200/6", i, alu_a, alu_b, alu_ctrl, e_valid, e_pc, e_rd);
            end
        end
        flush = 1;
        step();
        flush = 0; stall = 0;
        checks++; if (e_valid !== 0 || e_reg_write !== 0 || alu_ctrl !== 4'b0010) begin errors++; $display("[TB] FAIL flush_bubble: got v=%b rw=%b ctrl=%b expected 0/0/0010", e_valid, e_reg_write, alu_ctrl); end
        checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || e_pc !== 32'h0 || e_rd !== 5'd0) begin errors++; $display("[TB] FAIL flush_zeroed: got a=%h b=%h pc=%h rd=%0d expected 0", alu_a, alu_b, e_pc, e_rd); end
    endtask

    task automatic test_reset_midstream();
        clear_inputs();
        d_rs1_data = 32'h55; d_rs2_data = 32'h66; d_pc = 32'h300; d_rd = 5'd8;
        d_mem_read = 1; d_valid = 1;
        step();
        d_mem_read = 0; d_rs1 = 5'd8;
        #1;
        checks++; if (load_use_stall !== 1'b1 || e_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre: got lus=%b v=%b expected 1/1", load_use_stall, e_valid); end
        stall = 1; rst = 1;
        step();
        rst = 0; stall = 0;
        checks++; if (e_valid !== 0 || alu_a !== 32'h0 || alu_b !== 32'h0 || load_use_stall !== 0) begin errors++; $display("[TB] FAIL midrst: got v=%b a=%h b=%h lus=%b expected 0/0/0/0", e_valid, alu_a, alu_b, load_use_stall); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] aVals [3] = '{32'h1234, 32'h0, 32'hFFFF_FFFF};
        logic [WIDTH-1:0] bVals [3] = '{32'h9, 32'h8000_0000, 32'h1};
        logic [3:0]       cVals [3] = '{4'b0001, 4'b1000, 4'b0111};
        clear_inputs();
        d_valid = 1; d_rs1 = 5'd10; d_rs2 = 5'd11;
        for (int i = 0; i < 3; i++) begin
            d_rs1_data = aVals[i]; d_rs2_data = bVals[i]; d_alu_ctrl = cVals[i];
            step();
            checks++; if (alu_a !== aVals[i] || alu_b !== bVals[i] || alu_ctrl !== cVals[i] || e_valid !== 1) begin
                errors++; $display("[TB] FAIL b2b_%0d: got %h/%h/%b/%b expected %h/%h/%b/1", i, alu_a, alu_b, alu_ctrl, e_valid, aVals[i], bVals[i], cVals[i]);
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_capture();
        test_forward();
        test_x0();
        test_load_use();
        test_flush_stall();
        test_reset_midstream();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
